// File: rtl/uart_port.sv
// UART responder for the $FE00-$FEFF window: TX FIFO feeding an 8N1 serializer,
// 8N1 deserializer feeding a single RX holding register, CPU-visible DATA/STATUS.
module uart_port #(
    parameter int unsigned DIVISOR  = 234,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_i,
    input  logic       R_W_n,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       uart_tx_o,
    input  logic       uart_rx_i
);

    localparam int unsigned CNT_W = $clog2(DIVISOR);
    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(TX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Bus access decode
    logic data_wr, stat_wr, data_rd;
    assign data_wr = cs_i & ~R_W_n & (addr_i == 8'h00);
    assign stat_wr = cs_i & ~R_W_n & (addr_i == 8'h01);
    assign data_rd = cs_i &  R_W_n & (addr_i == 8'h00);

    // TX FIFO
    logic [7:0]       fifo_mem_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_empty, fifo_full, push, tx_pop;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign push       = data_wr & (~fifo_full | tx_pop);

    always_comb begin
        level_d = level_q;
        case ({push, tx_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (tx_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    // TX serializer
    state_e           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_line_d, tx_tick;

    assign tx_tick = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tx_state_q <= ST_IDLE;
        else       tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            ST_IDLE:  if (!fifo_empty) tx_state_d = ST_START;
            ST_START: if (tx_tick) tx_state_d = ST_DATA;
            ST_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = ST_STOP;
            ST_STOP:  if (tx_tick) tx_state_d = fifo_empty ? ST_IDLE : ST_START;
            default:  tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_pop     = 1'b0;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q];
                end
            end
            ST_START: begin
                tx_line_d = 1'b0;
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                end
            end
            ST_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end
            ST_STOP: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_mem_q[rd_ptr_q];
                    end
                end
            end
            default: tx_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_line_d;
        end
    end

    assign uart_tx_o = tx_q;

    // RX synchronizer and deserializer
    logic             rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
    state_e           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_tick, rx_half, rx_done_ok, rx_done_err;

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    assign rx_tick = (rx_cnt_q == BIT_LAST);
    assign rx_half = (rx_cnt_q == HALF_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rx_state_q <= ST_IDLE;
        else       rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            ST_IDLE:  if (rx_fall) rx_state_d = ST_START;
            ST_START: if (rx_half) rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            ST_STOP:  if (rx_tick) rx_state_d = ST_IDLE;
            default:  rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_d    = rx_cnt_q + CNT_W'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_done_ok  = 1'b0;
        rx_done_err = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end
            ST_START: if (rx_half) rx_cnt_d = '0;
            ST_DATA: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                end
            end
            ST_STOP: begin
                if (rx_tick) begin
                    rx_cnt_d    = '0;
                    rx_done_ok  = rx_sync_q;
                    rx_done_err = ~rx_sync_q;
                end
            end
            default: rx_cnt_d = '0;
        endcase
    end

    // Holding register and flags; a flag-setting event beats a STATUS write
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = rx_ovr_q;
        frame_err_d = frame_err_q;
        if (stat_wr) begin
            rx_ovr_d    = 1'b0;
            frame_err_d = 1'b0;
        end
        if (data_rd) rx_valid_d = 1'b0;
        if (rx_done_ok) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !data_rd) rx_ovr_d = 1'b1;
        end
        if (rx_done_err) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= uart_rx_i;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // CPU read mux
    logic       tx_idle;
    logic [7:0] status;
    assign tx_idle = fifo_empty & (tx_state_q == ST_IDLE);
    assign status  = {3'b000, frame_err_q, rx_ovr_q, tx_idle, fifo_full, rx_valid_q};

    always_comb begin
        data_o = 8'h00;
        if (cs_i) begin
            case (addr_i)
                8'h00:   data_o = rx_data_q;
                8'h01:   data_o = status;
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_port.sv
// Self-checking bench for uart_port with DIVISOR=4, TX_DEPTH=4.
module tb_uart_port;

    localparam int DIV = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cs_i = 1'b0;
    logic       R_W_n = 1'b1;
    logic [7:0] addr_i = 8'h00;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       uart_tx_o;
    logic       uart_rx_i = 1'b1;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int start_cyc[$];

    uart_port #(.DIVISOR(DIV), .TX_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .R_W_n(R_W_n),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Serial TX monitor: decodes frames mid-bit and compares against tx_exp
    always begin
        logic [7:0] got;
        @(negedge clk_i);
        if (mon_en && uart_tx_o === 1'b0) begin
            start_cyc.push_back(cyc);
            repeat (DIV / 2) @(negedge clk_i);
            n_checks++;
            if (uart_tx_o !== 1'b0) $display("FAIL mon_start: got %b want 0", uart_tx_o);
            else n_pass++;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk_i);
                got[i] = uart_tx_o;
            end
            repeat (DIV) @(negedge clk_i);
            n_checks++;
            if (uart_tx_o !== 1'b1) $display("FAIL mon_stop: got %b want 1", uart_tx_o);
            else n_pass++;
            n_checks++;
            if (tx_exp.size() == 0) begin
                $display("FAIL mon_unexpected_frame: got %02h want none", got);
            end else begin
                logic [7:0] e;
                e = tx_exp.pop_front();
                if (got !== e) $display("FAIL mon_byte: got %02h want %02h", got, e);
                else n_pass++;
            end
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        cs_i = 1'b1; R_W_n = 1'b0; addr_i = a; data_i = d;
        @(negedge clk_i);
        cs_i = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
        cs_i = 1'b1; R_W_n = 1'b1; addr_i = a;
        #1 v = data_o;
        @(negedge clk_i);
        cs_i = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx_i = 1'b0;
        repeat (DIV) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (DIV) @(negedge clk_i);
        end
        uart_rx_i = stop;
        repeat (DIV) @(negedge clk_i);
        uart_rx_i = 1'b1;
        if (stop) begin
            rx_exp.delete();
            rx_exp.push_back(b);
        end
        repeat (8) @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (uart_tx_o !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx_o);
        else n_pass++;
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (data_o !== 8'h00) $display("FAIL reset_dout_nocs: got %02h want 00", data_o);
        else n_pass++;
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL reset_status: got %02h want 04", v);
        else n_pass++;
        read_reg(8'h00, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL reset_rxdata: got %02h want 00", v);
        else n_pass++;
        read_reg(8'h05, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL unmapped_read: got %02h want 00", v);
        else n_pass++;
    endtask

    task automatic test_tx_single();
        logic [7:0] b;
        logic [7:0] v;
        logic       e;
        int         idx;
        b = 8'hA5;
        bus_write(8'h00, b);
        n_checks++;
        if (uart_tx_o !== 1'b1) $display("FAIL tx_lat1: got %b want 1", uart_tx_o);
        else n_pass++;
        @(negedge clk_i);
        n_checks++;
        if (uart_tx_o !== 1'b1) $display("FAIL tx_lat2: got %b want 1", uart_tx_o);
        else n_pass++;
        for (int k = 0; k < 10 * DIV; k++) begin
            @(negedge clk_i);
            cs_i = 1'b0;
            idx = k / DIV;
            if (idx == 0) e = 1'b0;
            else if (idx == 9) e = 1'b1;
            else e = b[idx-1];
            n_checks++;
            if (uart_tx_o !== e) $display("FAIL tx_wave[%0d]: got %b want %b", k, uart_tx_o, e);
            else n_pass++;
            if (k == 20) begin
                cs_i = 1'b1; R_W_n = 1'b1; addr_i = 8'h01;
                #1;
                n_checks++;
                if (data_o !== 8'h00) $display("FAIL tx_busy_status: got %02h want 00", data_o);
                else n_pass++;
            end
        end
        @(negedge clk_i);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL tx_done_status: got %02h want 04", v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        start_cyc.delete();
        mon_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_write(8'h00, 8'(i));
            tx_exp.push_back(8'(i));
        end
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL b2b_not_full: got %02h want 00", v);
        else n_pass++;
        bus_write(8'h00, 8'h05);
        tx_exp.push_back(8'h05);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h02) $display("FAIL b2b_full: got %02h want 02", v);
        else n_pass++;
        bus_write(8'h00, 8'h06);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h02) $display("FAIL b2b_full_after_drop: got %02h want 02", v);
        else n_pass++;
        for (int t = 0; t < 400 && tx_exp.size() != 0; t++) @(negedge clk_i);
        n_checks++;
        if (tx_exp.size() != 0) $display("FAIL b2b_timeout: got %0d pending want 0", tx_exp.size());
        else n_pass++;
        repeat (60) @(negedge clk_i);
        mon_en = 1'b0;
        n_checks++;
        if (start_cyc.size() != 5) $display("FAIL b2b_frames: got %0d want 5", start_cyc.size());
        else n_pass++;
        for (int i = 1; i < start_cyc.size(); i++) begin
            n_checks++;
            if (start_cyc[i] - start_cyc[i-1] != 10 * DIV)
                $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, start_cyc[i] - start_cyc[i-1], 10 * DIV);
            else n_pass++;
        end
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL b2b_idle: got %02h want 04", v);
        else n_pass++;
    endtask

    task automatic check_rx_data();
        logic [7:0] v;
        read_reg(8'h00, v);
        n_checks++;
        if (rx_exp.size() == 0) begin
            $display("FAIL rx_data_unexpected: got %02h want none", v);
        end else begin
            logic [7:0] e;
            e = rx_exp.pop_front();
            if (v !== e) $display("FAIL rx_data: got %02h want %02h", v, e);
            else n_pass++;
        end
    endtask

    task automatic test_rx_basic();
        logic [7:0] v;
        send_rx(8'h3C, 1'b1);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h05) $display("FAIL rx_basic_status: got %02h want 05", v);
        else n_pass++;
        check_rx_data();
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL rx_basic_cleared: got %02h want 04", v);
        else n_pass++;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] v;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h0D) $display("FAIL ovr_status: got %02h want 0D", v);
        else n_pass++;
        check_rx_data();
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h0C) $display("FAIL ovr_after_read: got %02h want 0C", v);
        else n_pass++;
        bus_write(8'h01, 8'hFF);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL ovr_clear: got %02h want 04", v);
        else n_pass++;
    endtask

    task automatic test_rx_frame_err();
        logic [7:0] v;
        send_rx(8'h7E, 1'b0);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h14) $display("FAIL ferr_status: got %02h want 14", v);
        else n_pass++;
        bus_write(8'h01, 8'h00);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL ferr_clear: got %02h want 04", v);
        else n_pass++;
    endtask

    task automatic test_rx_glitch();
        logic [7:0] v;
        uart_rx_i = 1'b0;
        @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (12 * DIV) @(negedge clk_i);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL glitch_status: got %02h want 04", v);
        else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] v;
        bit         stayed_high;
        bus_write(8'h00, 8'h00);
        bus_write(8'h00, 8'hFF);
        repeat (10) @(negedge clk_i);
        n_checks++;
        if (uart_tx_o !== 1'b0) $display("FAIL midtx_low: got %b want 0", uart_tx_o);
        else n_pass++;
        #2 rst_i = 1'b1;
        #1;
        n_checks++;
        if (uart_tx_o !== 1'b1) $display("FAIL midtx_async_tx: got %b want 1", uart_tx_o);
        else n_pass++;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        read_reg(8'h01, v);
        n_checks++;
        if (v !== 8'h04) $display("FAIL midtx_status: got %02h want 04", v);
        else n_pass++;
        stayed_high = 1'b1;
        for (int t = 0; t < 15 * DIV; t++) begin
            @(negedge clk_i);
            if (uart_tx_o !== 1'b1) stayed_high = 1'b0;
        end
        n_checks++;
        if (!stayed_high) $display("FAIL midtx_fifo_flushed: got activity want idle line");
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_basic();
        test_rx_overrun();
        test_rx_frame_err();
        test_rx_glitch();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
